// File: rtl/rs_issue_if.sv
// Dispatch / wakeup / issue signal bundle for the reservation-station scheduler.
// master = dispatch and functional-unit side, slave = scheduler.
interface rs_issue_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned IDX_W = 2
);
  logic             flush_i;
  logic             alloc_valid_i;
  logic             alloc_rdy_i;
  logic             alloc_ready_o;
  logic [IDX_W-1:0] alloc_idx_o;
  logic [SIZE-1:0]  wakeup_i;
  logic             issue_valid_o;
  logic [IDX_W-1:0] issue_idx_o;
  logic             issue_ready_i;
  logic [SIZE-1:0]  entry_valid_o;
  logic [SIZE-1:0]  entry_ready_o;
  logic [IDX_W:0]   count_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_rdy_i, wakeup_i, issue_ready_i,
    input  alloc_ready_o, alloc_idx_o, issue_valid_o, issue_idx_o,
           entry_valid_o, entry_ready_o, count_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_rdy_i, wakeup_i, issue_ready_i,
    output alloc_ready_o, alloc_idx_o, issue_valid_o, issue_idx_o,
           entry_valid_o, entry_ready_o, count_o
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Allocate / wakeup / oldest-ready issue controller for a small reservation station.
// The offered index is locked while the functional unit stalls.
module rs_issue_scheduler #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned AGE_W = 3
) (
  input logic       clk_i,
  input logic       reset_i,
  rs_issue_if.slave rs
);
  localparam int unsigned      CNT_W   = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {S_IDLE, S_OFFER} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SIZE-1:0]  r_valid;
  logic [SIZE-1:0]  r_ready;
  logic [AGE_W-1:0] r_age [SIZE];
  logic [IDX_W-1:0] r_lock_idx;
  logic [CNT_W-1:0] r_count;

  logic             w_alloc_ready;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_alloc_acc;
  logic             w_any_cand;
  logic [IDX_W-1:0] w_sel_idx;
  logic [AGE_W-1:0] w_sel_age;
  logic             w_issue_valid;
  logic [IDX_W-1:0] w_issue_idx;
  logic             w_issue_acc;

  // Lowest free slot; descending scan so the lowest index wins, 0 when full
  always_comb begin
    w_alloc_idx = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (!r_valid[k]) w_alloc_idx = IDX_W'(k);
    end
  end

  assign w_alloc_ready = ~(&r_valid) & ~rs.flush_i;
  assign w_alloc_acc   = rs.alloc_valid_i & w_alloc_ready;

  // Oldest ready entry; strict compare keeps the lower index on equal ages
  always_comb begin
    w_any_cand = 1'b0;
    w_sel_idx  = '0;
    w_sel_age  = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (r_valid[k] && r_ready[k] && (!w_any_cand || r_age[k] > w_sel_age)) begin
        w_any_cand = 1'b1;
        w_sel_idx  = IDX_W'(k);
        w_sel_age  = r_age[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rs.flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_any_cand && !rs.issue_ready_i) w_state_nxt = S_OFFER;
        S_OFFER: if (rs.issue_ready_i) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_issue_valid = 1'b0;
    w_issue_idx   = w_sel_idx;
    case (r_state)
      S_IDLE:  w_issue_valid = w_any_cand;
      S_OFFER: begin
        w_issue_valid = 1'b1;
        w_issue_idx   = r_lock_idx;
      end
      default: w_issue_valid = 1'b0;
    endcase
    if (rs.flush_i) w_issue_valid = 1'b0;
  end

  assign w_issue_acc = w_issue_valid & rs.issue_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                                       r_lock_idx <= '0;
    else if (r_state == S_IDLE && w_state_nxt == S_OFFER) r_lock_idx <= w_sel_idx;
  end

  // Entry state: issue clears, allocation fills a free slot, survivors age on allocation
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid <= '0;
      r_ready <= '0;
      r_count <= '0;
      for (int k = 0; k < SIZE; k++) r_age[k] <= '0;
    end else if (rs.flush_i) begin
      r_valid <= '0;
      r_ready <= '0;
      r_count <= '0;
      for (int k = 0; k < SIZE; k++) r_age[k] <= '0;
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        if (w_issue_acc && w_issue_idx == IDX_W'(k)) begin
          r_valid[k] <= 1'b0;
          r_ready[k] <= 1'b0;
          r_age[k]   <= '0;
        end else if (w_alloc_acc && w_alloc_idx == IDX_W'(k)) begin
          r_valid[k] <= 1'b1;
          r_ready[k] <= rs.alloc_rdy_i | rs.wakeup_i[k];
          r_age[k]   <= '0;
        end else if (r_valid[k]) begin
          if (rs.wakeup_i[k]) r_ready[k] <= 1'b1;
          if (w_alloc_acc && r_age[k] != AGE_MAX) r_age[k] <= r_age[k] + AGE_W'(1);
        end
      end
      r_count <= r_count + CNT_W'(w_alloc_acc) - CNT_W'(w_issue_acc);
    end
  end

  assign rs.alloc_ready_o = w_alloc_ready;
  assign rs.alloc_idx_o   = w_alloc_idx;
  assign rs.issue_valid_o = w_issue_valid;
  assign rs.issue_idx_o   = w_issue_idx;
  assign rs.entry_valid_o = r_valid;
  assign rs.entry_ready_o = r_ready;
  assign rs.count_o       = r_count;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed vector bench for rs_issue_scheduler: a per-cycle table of inputs and
// hand-derived outputs, plus a hand-written asynchronous-reset-during-offer sequence.
module tb_rs_issue_scheduler;
  logic clk;
  logic reset_i;

  rs_issue_if #(.SIZE(4), .IDX_W(2)) rs_bus ();

  rs_issue_scheduler #(.SIZE(4), .IDX_W(2), .AGE_W(3)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .rs      (rs_bus)
  );

  typedef struct {
    logic       fl;
    logic       av;
    logic       ardy;
    logic [3:0] wk;
    logic       ir;
    logic       e_ar;
    logic [1:0] e_ai;
    logic       e_iv;
    logic [1:0] e_ii;
    logic       chk_ii;
    logic [3:0] e_ev;
    logic [3:0] e_er;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic fl, av, ardy, input logic [3:0] wk, input logic ir,
                     input logic e_ar, input logic [1:0] e_ai, input logic e_iv,
                     input logic [1:0] e_ii, input logic chk_ii,
                     input logic [3:0] e_ev, e_er, input logic [2:0] e_cnt);
    vec_t t;
    t.fl = fl; t.av = av; t.ardy = ardy; t.wk = wk; t.ir = ir;
    t.e_ar = e_ar; t.e_ai = e_ai; t.e_iv = e_iv; t.e_ii = e_ii; t.chk_ii = chk_ii;
    t.e_ev = e_ev; t.e_er = e_er; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic fl, av, ardy, input logic [3:0] wk, input logic ir);
    rs_bus.flush_i       = fl;
    rs_bus.alloc_valid_i = av;
    rs_bus.alloc_rdy_i   = ardy;
    rs_bus.wakeup_i      = wk;
    rs_bus.issue_ready_i = ir;
  endtask

  task automatic check(input string name, input logic e_ar, input logic [1:0] e_ai,
                       input logic e_iv, input logic [1:0] e_ii, input logic chk_ii,
                       input logic [3:0] e_ev, e_er, input logic [2:0] e_cnt);
    logic bad;
    n_vec++;
    bad = (rs_bus.alloc_ready_o !== e_ar) || (rs_bus.alloc_idx_o !== e_ai) ||
          (rs_bus.issue_valid_o !== e_iv) || (chk_ii && rs_bus.issue_idx_o !== e_ii) ||
          (rs_bus.entry_valid_o !== e_ev) || (rs_bus.entry_ready_o !== e_er) ||
          (rs_bus.count_o !== e_cnt);
    if (bad) begin
      n_miss++;
      $display("FAIL %s: got ar=%b ai=%0d iv=%b ii=%0d ev=%b er=%b cnt=%0d ; want ar=%b ai=%0d iv=%b ii=%0d ev=%b er=%b cnt=%0d",
               name, rs_bus.alloc_ready_o, rs_bus.alloc_idx_o, rs_bus.issue_valid_o,
               rs_bus.issue_idx_o, rs_bus.entry_valid_o, rs_bus.entry_ready_o, rs_bus.count_o,
               e_ar, e_ai, e_iv, e_ii, e_ev, e_er, e_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    //   fl av rdy wake    ir | ar ai iv ii chk ev       er       cnt
    add(0, 1, 0, 4'b0000, 1,  1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0); // fill 0..3
    add(0, 1, 0, 4'b0000, 1,  1, 1, 0, 0, 1, 4'b0001, 4'b0000, 1);
    add(0, 1, 0, 4'b0000, 1,  1, 2, 0, 0, 1, 4'b0011, 4'b0000, 2);
    add(0, 1, 0, 4'b0000, 1,  1, 3, 0, 0, 1, 4'b0111, 4'b0000, 3);
    add(0, 1, 0, 4'b0000, 1,  0, 0, 0, 0, 1, 4'b1111, 4'b0000, 4); // fifth alloc ignored
    add(0, 0, 0, 4'b1010, 1,  0, 0, 0, 0, 1, 4'b1111, 4'b0000, 4); // wake 1,3
    add(0, 0, 0, 4'b0000, 1,  0, 0, 1, 1, 1, 4'b1111, 4'b1010, 4); // age 2 beats 0
    add(0, 0, 0, 4'b0000, 1,  1, 1, 1, 3, 1, 4'b1101, 4'b1000, 3);
    add(0, 1, 1, 4'b0000, 1,  1, 1, 0, 0, 1, 4'b0101, 4'b0000, 2); // refill 1 ready
    add(0, 0, 0, 4'b0000, 0,  1, 3, 1, 1, 1, 4'b0111, 4'b0010, 3); // stall -> lock 1
    add(0, 0, 0, 4'b0001, 0,  1, 3, 1, 1, 1, 4'b0111, 4'b0010, 3); // wake older 0
    add(0, 0, 0, 4'b0000, 0,  1, 3, 1, 1, 1, 4'b0111, 4'b0011, 3); // offer held
    add(0, 0, 0, 4'b0000, 1,  1, 3, 1, 1, 1, 4'b0111, 4'b0011, 3); // accept 1
    add(0, 0, 0, 4'b0000, 0,  1, 1, 1, 0, 1, 4'b0101, 4'b0001, 2); // next offer 0, lock
    add(0, 1, 0, 4'b0000, 0,  1, 1, 1, 0, 1, 4'b0101, 4'b0001, 2);
    add(0, 1, 0, 4'b0000, 0,  1, 3, 1, 0, 1, 4'b0111, 4'b0001, 3);
    add(0, 1, 0, 4'b0000, 1,  0, 0, 1, 0, 1, 4'b1111, 4'b0001, 4); // full, issue + alloc
    add(0, 1, 0, 4'b0000, 1,  1, 0, 0, 0, 1, 4'b1110, 4'b0000, 3); // freed slot next cycle
    add(0, 1, 0, 4'b1011, 1,  0, 0, 0, 0, 1, 4'b1111, 4'b0000, 4);
    add(0, 1, 1, 4'b0000, 1,  0, 0, 1, 1, 1, 4'b1111, 4'b1011, 4);
    add(0, 1, 1, 4'b0000, 1,  1, 1, 1, 3, 1, 4'b1101, 4'b1001, 3); // churn: entry 2 ages
    add(0, 1, 1, 4'b0000, 1,  1, 3, 1, 0, 1, 4'b0111, 4'b0011, 3);
    add(0, 1, 1, 4'b0000, 1,  1, 0, 1, 1, 1, 4'b1110, 4'b1010, 3);
    add(0, 1, 1, 4'b0100, 1,  1, 1, 1, 3, 1, 4'b1101, 4'b1001, 3);
    add(0, 0, 0, 4'b0000, 0,  1, 3, 1, 2, 1, 4'b0111, 4'b0111, 3); // saturated 7 beats 1
    add(1, 1, 1, 4'b1000, 1,  0, 3, 0, 0, 0, 4'b0111, 4'b0111, 3); // flush in OFFER
    add(0, 1, 0, 4'b0011, 0,  1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0); // alloc + same-cycle wake
    add(0, 0, 0, 4'b0000, 1,  1, 1, 1, 0, 1, 4'b0001, 4'b0001, 1); // IDLE, idx from selection
    add(0, 0, 0, 4'b0000, 0,  1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);

    drive(0, 0, 0, 4'b0000, 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset", 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    reset_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].fl, vecs[i].av, vecs[i].ardy, vecs[i].wk, vecs[i].ir);
      #1 check($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_ai, vecs[i].e_iv,
               vecs[i].e_ii, vecs[i].chk_ii, vecs[i].e_ev, vecs[i].e_er, vecs[i].e_cnt);
    end

    // Asynchronous reset while an offer is locked
    @(negedge clk);
    drive(0, 1, 1, 4'b0000, 0);
    #1 check("pre_offer", 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    drive(0, 0, 0, 4'b0000, 0);
    #1 check("offer", 1, 1, 1, 0, 1, 4'b0001, 4'b0001, 1);
    @(negedge clk);
    #1 check("offer_hold", 1, 1, 1, 0, 1, 4'b0001, 4'b0001, 1);
    #2 reset_i = 1'b0;
    #1 check("async_reset", 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    reset_i = 1'b1;
    #1 check("post_reset", 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    #1 check("post_reset_idle", 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
